// File: rtl/program_counter.sv
// Fetch-stage PC register: picks the next PC from the adder, branch target or jump target under run/stall/halt control.
// Optional PC_ALIGN_CHECK_EN: word-aligns misaligned branch/jump targets and raises sticky o_misalign_err.
module program_counter #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_run,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [PC_WIDTH-1:0]  i_branch_target,
    input  logic                 i_jump,
    input  logic [PC_WIDTH-1:0]  i_jump_target,
    input  logic                 i_halt,
    input  logic [PC_WIDTH-1:0]  i_pc_plus_four,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic                 o_pc_valid,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_fetch_count,
    output logic                 o_misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [PC_WIDTH-1:0] target;
    logic                load_target;
    logic                pc_write;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = o_pc;
        target      = i_jump_target;
        load_target = 1'b0;
        pc_write    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_run) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Dropping i_run parks the fetch without touching the PC.
                if (!i_run) begin
                    state_nxt = S_IDLE;
                end else if (i_branch_taken) begin
                    target      = i_branch_target;
                    load_target = 1'b1;
                    pc_write    = 1'b1;
                end else if (i_stall) begin
                    pc_write = 1'b0;
                end else if (i_halt) begin
                    state_nxt = S_HALTED;
                end else if (i_jump) begin
                    load_target = 1'b1;
                    pc_write    = 1'b1;
                end else begin
                    pc_nxt   = i_pc_plus_four;
                    pc_write = 1'b1;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if (load_target) pc_nxt = {target[PC_WIDTH-1:2], 2'b00};
`else
        if (load_target) pc_nxt = target;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            o_pc          <= RESET_PC;
            o_fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (pc_write) begin
                o_pc          <= pc_nxt;
                o_fetch_count <= o_fetch_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (load_target && (target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    assign o_misalign_err = misalign_err;
`else
    assign o_misalign_err = 1'b0;
`endif

    assign o_pc_valid = (state == S_RUN);
    assign o_halted   = (state == S_HALTED);

endmodule
